// File: rtl/regfile_sb.sv
// Register bank with two combinational read ports, two write ports and a pending-write
// scoreboard for long-latency ops. Define REGFILE_BYPASS_EN for write-through reads.
module regfile_sb #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 4,
  parameter int PC_IDX      = 15,
  parameter int MAX_PENDING = 4
) (
  input  logic                                 CLK,
  input  logic                                 RESET,
  input  logic [ADDR_W-1:0]                    RA1,
  input  logic [ADDR_W-1:0]                    RA2,
  output logic [DATA_W-1:0]                    RD1,
  output logic [DATA_W-1:0]                    RD2,
  output logic                                 BUSY1,
  output logic                                 BUSY2,
  input  logic [DATA_W-1:0]                    PC,
  input  logic                                 WE,
  input  logic [ADDR_W-1:0]                    WA,
  input  logic [DATA_W-1:0]                    WD,
  input  logic                                 LWE,
  input  logic [ADDR_W-1:0]                    LWA,
  input  logic [DATA_W-1:0]                    LWD,
  input  logic                                 ISSUE_VALID,
  input  logic [ADDR_W-1:0]                    ISSUE_ADDR,
  output logic                                 ISSUE_READY,
  output logic [$clog2(MAX_PENDING+1)-1:0]     PENDING_CNT,
  output logic                                 SB_ERR
);
  localparam int NREG  = 2 ** ADDR_W;
  localparam int CNT_W = $clog2(MAX_PENDING + 1);
  localparam logic [ADDR_W-1:0] PC_A  = ADDR_W'(PC_IDX);
  localparam logic [CNT_W-1:0]  MAX_C = CNT_W'(MAX_PENDING);

  logic [DATA_W-1:0] bank_q [NREG];
  logic [NREG-1:0]   busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              issue_ready, lwe_hit, issue_ok, issue_err, lwe_err;

  assign issue_ready = (cnt_q < MAX_C);
  assign lwe_hit     = LWE && busy_q[LWA];

  // An issue to a busy register is legal only when that register completes this same cycle.
  assign issue_ok  = ISSUE_VALID && issue_ready && (ISSUE_ADDR != PC_A) &&
                     (!busy_q[ISSUE_ADDR] || (lwe_hit && (LWA == ISSUE_ADDR)));
  assign issue_err = ISSUE_VALID && (!issue_ready ||
                     ((ISSUE_ADDR != PC_A) && busy_q[ISSUE_ADDR] &&
                      !(lwe_hit && (LWA == ISSUE_ADDR))));
  assign lwe_err   = LWE && !busy_q[LWA];

  always_comb begin
    busy_d = busy_q;
    if (lwe_hit)  busy_d[LWA] = 1'b0;
    if (issue_ok) busy_d[ISSUE_ADDR] = 1'b1;
    cnt_d = cnt_q + CNT_W'(issue_ok) - CNT_W'(lwe_hit);
    err_d = err_q | issue_err | lwe_err;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NREG; i++) bank_q[i] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      // Primary port is younger in program order, so it wins an address collision.
      if (LWE && (LWA != PC_A) && !(WE && (WA == LWA))) bank_q[LWA] <= LWD;
      if (WE && (WA != PC_A)) bank_q[WA] <= WD;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic [ADDR_W-1:0] ra_v;
      logic [DATA_W-1:0] rd_v;
      logic              busy_v;
      assign ra_v = (gi == 0) ? RA1 : RA2;
      always_comb begin
        rd_v   = bank_q[ra_v];
        busy_v = busy_q[ra_v];
`ifdef REGFILE_BYPASS_EN
        if (LWE && (LWA == ra_v)) begin
          rd_v   = LWD;
          busy_v = 1'b0;
        end
        if (WE && (WA == ra_v)) rd_v = WD;
`endif
        if (ra_v == PC_A) begin
          rd_v   = PC;
          busy_v = 1'b0;
        end
      end
    end
  endgenerate

  assign RD1         = g_rd[0].rd_v;
  assign RD2         = g_rd[1].rd_v;
  assign BUSY1       = g_rd[0].busy_v;
  assign BUSY2       = g_rd[1].busy_v;
  assign ISSUE_READY = issue_ready;
  assign PENDING_CNT = cnt_q;
  assign SB_ERR      = err_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: behavioural model feeds a scoreboard queue each cycle, plus directed checks.
module tb_regfile_sb;
  logic        CLK = 1'b0;
  logic        RESET;
  logic [3:0]  RA1, RA2, WA, LWA, ISSUE_ADDR;
  logic [31:0] RD1, RD2, PC, WD, LWD;
  logic        BUSY1, BUSY2, WE, LWE, ISSUE_VALID, ISSUE_READY, SB_ERR;
  logic [2:0]  PENDING_CNT;

  regfile_sb #(.DATA_W(32), .ADDR_W(4), .PC_IDX(15), .MAX_PENDING(4)) dut (
    .CLK(CLK), .RESET(RESET), .RA1(RA1), .RA2(RA2), .RD1(RD1), .RD2(RD2),
    .BUSY1(BUSY1), .BUSY2(BUSY2), .PC(PC), .WE(WE), .WA(WA), .WD(WD),
    .LWE(LWE), .LWA(LWA), .LWD(LWD), .ISSUE_VALID(ISSUE_VALID),
    .ISSUE_ADDR(ISSUE_ADDR), .ISSUE_READY(ISSUE_READY),
    .PENDING_CNT(PENDING_CNT), .SB_ERR(SB_ERR));

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        b1;
    logic        b2;
    logic        rdy;
    logic        err;
    logic [2:0]  cnt;
  } exp_t;
  exp_t sb_q[$];

  logic [31:0] m_bank [16];
  bit          m_busy [16];
  int          m_cnt;
  bit          m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] m_rd(input logic [3:0] ra);
    logic [31:0] v;
    if (ra == 4'd15) return PC;
    v = m_bank[ra];
`ifdef REGFILE_BYPASS_EN
    if (LWE && LWA == ra) v = LWD;
    if (WE && WA == ra) v = WD;
`endif
    return v;
  endfunction

  function automatic logic m_bsy(input logic [3:0] ra);
    if (ra == 4'd15) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (LWE && LWA == ra) return 1'b0;
`endif
    return m_busy[ra];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_bank[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_cnt = 0;
    m_err = 1'b0;
  endtask

  task automatic model_edge();
    bit completes, accept;
    if (RESET) begin
      model_reset();
      return;
    end
    completes = LWE && LWA != 4'd15 && m_busy[LWA];
    accept    = 1'b0;
    if (LWE && !completes) m_err = 1'b1;
    if (ISSUE_VALID) begin
      if (m_cnt >= 4) m_err = 1'b1;
      else if (ISSUE_ADDR == 4'd15) accept = 1'b0;
      else if (m_busy[ISSUE_ADDR] && !(completes && LWA == ISSUE_ADDR)) m_err = 1'b1;
      else accept = 1'b1;
    end
    if (LWE && LWA != 4'd15 && !(WE && WA == LWA)) m_bank[LWA] = LWD;
    if (WE && WA != 4'd15) m_bank[WA] = WD;
    if (completes) begin
      m_busy[LWA] = 1'b0;
      m_cnt--;
    end
    if (accept) begin
      m_busy[ISSUE_ADDR] = 1'b1;
      m_cnt++;
    end
  endtask

  // One clock: push the model's expectation, compare at the falling edge, then advance.
  task automatic tick();
    exp_t e;
    e.rd1 = m_rd(RA1);
    e.rd2 = m_rd(RA2);
    e.b1  = m_bsy(RA1);
    e.b2  = m_bsy(RA2);
    e.rdy = (m_cnt < 4);
    e.err = m_err;
    e.cnt = 3'(m_cnt);
    sb_q.push_back(e);
    @(negedge CLK);
    e = sb_q.pop_front();
    check("sb_rd1", RD1, e.rd1);
    check("sb_rd2", RD2, e.rd2);
    check("sb_busy1", BUSY1, e.b1);
    check("sb_busy2", BUSY2, e.b2);
    check("sb_ready", ISSUE_READY, e.rdy);
    check("sb_err", SB_ERR, e.err);
    check("sb_cnt", PENDING_CNT, e.cnt);
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic idle();
    RESET = 0; WE = 0; LWE = 0; ISSUE_VALID = 0;
  endtask

  task automatic issue(input logic [3:0] a);
    idle();
    ISSUE_VALID = 1; ISSUE_ADDR = a;
    tick();
  endtask

  task automatic do_reset();
    idle();
    RESET = 1;
    tick();
    RESET = 0;
  endtask

  initial begin
    RESET = 1; WE = 0; LWE = 0; ISSUE_VALID = 0;
    RA1 = 0; RA2 = 15; WA = 0; LWA = 0; ISSUE_ADDR = 0;
    WD = 0; LWD = 0; PC = 32'h100;
    repeat (2) @(posedge CLK);
    #1;
    model_reset();
    RESET = 0;
    #1;
    check("rst_ready", ISSUE_READY, 1);
    check("rst_cnt", PENDING_CNT, 0);
    check("rst_err", SB_ERR, 0);
    check("rst_rd1", RD1, 0);
    check("rst_pc", RD2, 32'h100);

    // Primary write and PC substitution
    WE = 1; WA = 3; WD = 32'hDEADBEEF; tick();
    idle(); RA1 = 3; RA2 = 15; #1;
    check("wr3_rd1", RD1, 32'hDEADBEEF);
    check("pc_rd2", RD2, 32'h100);
    WE = 1; WA = 15; WD = 32'h123; tick();
    idle(); #1;
    check("pc_nowrite", RD2, 32'h100);

    // Issue then complete
    issue(5);
    idle(); RA1 = 5; #1;
    check("iss5_busy", BUSY1, 1);
    check("iss5_cnt", PENDING_CNT, 1);
    tick(); tick();
    LWE = 1; LWA = 5; LWD = 32'h42; tick();
    idle(); #1;
    check("cmp5_busy", BUSY1, 0);
    check("cmp5_rd", RD1, 32'h42);
    check("cmp5_cnt", PENDING_CNT, 0);

    // Fill to MAX_PENDING, overflow issue is an error
    for (int k = 1; k <= 4; k++) issue(4'(k));
    idle(); #1;
    check("full_ready", ISSUE_READY, 0);
    check("full_cnt", PENDING_CNT, 4);
    issue(6);
    idle(); RA1 = 6; #1;
    check("ovf_busy6", BUSY1, 0);
    check("ovf_err", SB_ERR, 1);
    check("ovf_cnt", PENDING_CNT, 4);
    do_reset(); #1;
    check("rst2_err", SB_ERR, 0);
    check("rst2_cnt", PENDING_CNT, 0);

    // Dual write collision and issue/complete on different addresses
    issue(7);
    issue(9);
    idle(); WE = 1; WA = 7; WD = 32'h11; LWE = 1; LWA = 7; LWD = 32'h22; tick();
    idle(); RA1 = 7; #1;
    check("coll_rd", RD1, 32'h11);
    check("coll_busy", BUSY1, 0);
    check("coll_cnt", PENDING_CNT, 1);
    ISSUE_VALID = 1; ISSUE_ADDR = 8; LWE = 1; LWA = 9; LWD = 32'h99; tick();
    idle(); RA1 = 8; RA2 = 9; #1;
    check("net_cnt", PENDING_CNT, 1);
    check("net_err", SB_ERR, 0);
    check("net_busy8", BUSY1, 1);
    check("net_rd9", RD2, 32'h99);

    // Completion to a non-busy register
    LWE = 1; LWA = 10; LWD = 32'h5; tick();
    idle(); RA1 = 10; #1;
    check("nb_rd", RD1, 32'h5);
    check("nb_err", SB_ERR, 1);
    check("nb_cnt", PENDING_CNT, 1);

    // Same-address issue+completion, then issue to a busy register
    do_reset();
    issue(8);
    ISSUE_VALID = 1; ISSUE_ADDR = 8; LWE = 1; LWA = 8; LWD = 32'h77; tick();
    idle(); RA1 = 8; #1;
    check("same_busy", BUSY1, 1);
    check("same_cnt", PENDING_CNT, 1);
    check("same_err", SB_ERR, 0);
    check("same_rd", RD1, 32'h77);
    issue(8);
    idle(); #1;
    check("dup_err", SB_ERR, 1);
    check("dup_cnt", PENDING_CNT, 1);

    // Same-cycle read of a register being written
    do_reset();
    WE = 1; WA = 2; WD = 32'hA5; RA1 = 2; #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_rd", RD1, 32'hA5);
`else
    check("byp_rd", RD1, 32'h0);
`endif
    tick();
    idle(); #1;
    check("post_rd", RD1, 32'hA5);

    // Reset with ops in flight
    issue(1);
    issue(2);
    do_reset();
    RA1 = 1; RA2 = 2; #1;
    check("rstp_b1", BUSY1, 0);
    check("rstp_b2", BUSY2, 0);
    check("rstp_cnt", PENDING_CNT, 0);
    check("rstp_ready", ISSUE_READY, 1);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      int cand;
      RESET       = ($urandom_range(0, 49) == 0);
      WE          = $urandom_range(0, 1);
      WA          = 4'($urandom_range(0, 15));
      WD          = $urandom;
      ISSUE_VALID = $urandom_range(0, 1);
      ISSUE_ADDR  = 4'($urandom_range(0, 15));
      LWE         = ($urandom_range(0, 2) == 0);
      LWA         = 4'($urandom_range(0, 15));
      LWD         = $urandom;
      if (LWE && m_cnt > 0 && $urandom_range(0, 3) != 0) begin
        cand = $urandom_range(0, 15);
        for (int s = 0; s < 16; s++)
          if (m_busy[(cand + s) % 16]) begin
            LWA = 4'((cand + s) % 16);
            break;
          end
      end
      RA1 = 4'($urandom_range(0, 15));
      RA2 = ($urandom_range(0, 1) == 0) ? LWA : 4'($urandom_range(0, 15));
      PC  = $urandom;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
